// File: rtl/patch_pkg.sv
// Shared types and default constants for the patch fetch controller.
// The PATCH_TIMEOUT_EN build uses TIMEOUT_CYCLES to bound the cache wait.
package patch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int TIMEOUT_CYCLES = 255;

  localparam int DEF_N          = 16;
  localparam int DEF_M          = 16;
  localparam int DEF_ADDR_WIDTH = 21;
  localparam int DEF_STRIDE     = 1;

endpackage

// File: rtl/patch_fetch_ctrl_if.sv
// Cache-side bus of the patch fetch controller: read requests out, one response
// back per request, plus the lane-steering strobe for the activation register file.
interface patch_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int M          = 16
);
  localparam int IW = $clog2(M);

  // request is a one-cycle strobe with address stable from that cycle until the
  // response; exactly one response (cache_valid and/or cache_error) is expected per
  // request, no earlier than the cycle after the strobe and with no upper bound.
  // error wins when both response bits are high; store_enable only accompanies a
  // clean valid response and names its lane on index.
  logic                  request;
  logic                  read_write;
  logic [ADDR_WIDTH-1:0] address;
  logic                  cache_valid;
  logic                  cache_error;
  logic [IW-1:0]         index;
  logic                  store_enable;

  modport master (
    output request, read_write, address, index, store_enable,
    input  cache_valid, cache_error
  );

  modport slave (
    input  request, read_write, address, index, store_enable,
    output cache_valid, cache_error
  );

endinterface

// File: rtl/patch_fetch_ctrl.sv
// Patch fetch sequencer: reads M strided cache lines per start and builds the patch mask.
// Define PATCH_TIMEOUT_EN to give up on a lane after TIMEOUT_CYCLES cycles of silence.
module patch_fetch_ctrl
  import patch_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int M          = DEF_M,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int STRIDE     = DEF_STRIDE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [M-1:0]          p_mask,
  output logic [$clog2(M):0]    err_count,
  output state_t                state_dbg,
  patch_fetch_ctrl_if.master    cache
);

  localparam int                    IW        = $clog2(M);
  localparam logic [IW-1:0]         LAST_LANE = IW'(M - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(STRIDE);

  state_t                state_q;
  state_t                state_d;
  logic [IW-1:0]         lane_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [M-1:0]          mask_q;
  logic [IW:0]           err_q;
  logic                  accept;
  logic                  resp_hit;
  logic                  resp_err;
  logic                  tmo_expired;
  logic                  unused_n;

  // Activation width only matters to the datapath this block steers.
  assign unused_n = (N > 0);

`ifdef PATCH_TIMEOUT_EN
  logic [7:0] tmo_q;

  // Counts WAIT cycles; the 255th silent cycle is treated as the error response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (state_q != WAIT) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 8'd1;
    end
  end

  assign tmo_expired = (tmo_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && start;
  // A real response always beats an expiring timeout in the same cycle.
  assign resp_hit = (state_q == WAIT) && cache.cache_valid && !cache.cache_error;
  assign resp_err = (state_q == WAIT) &&
                    (cache.cache_error || (!cache.cache_valid && tmo_expired));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= base_addr;
        lane_q <= '0;
        mask_q <= '0;
        err_q  <= '0;
      end
      if (resp_hit) begin
        mask_q[lane_q] <= 1'b1;
      end
      if (resp_err) begin
        err_q <= err_q + 1'b1;
      end
      // Address advances by accumulation, wrapping silently at 2^ADDR_WIDTH.
      if ((state_q == NEXT) && (lane_q != LAST_LANE)) begin
        lane_q <= lane_q + 1'b1;
        addr_q <= addr_q + STEP;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    cache.request = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        busy          = 1'b1;
        cache.request = 1'b1;
        state_d       = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (resp_hit || resp_err) state_d = NEXT;
      end
      NEXT: begin
        busy    = 1'b1;
        state_d = (lane_q == LAST_LANE) ? DONE : ISSUE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cache.read_write   = 1'b1;
  assign cache.address      = addr_q;
  assign cache.index        = lane_q;
  assign cache.store_enable = resp_hit;

  assign p_mask    = mask_q;
  assign err_count = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_patch_fetch_ctrl.sv
// Directed bench for patch_fetch_ctrl: per-lane cache latency/response tables,
// a sequence-level model of addresses, stores, mask and done timing, checked every cycle.
`timescale 1ns/1ps
module tb_patch_fetch_ctrl;
  import patch_pkg::*;

  localparam int M      = 16;
  localparam int AW     = 21;
  localparam int STRIDE = 1;
  localparam int IW     = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic           busy;
  logic           done;
  logic [M-1:0]   p_mask;
  logic [IW:0]    err_count;
  state_t         state_dbg;

  patch_fetch_ctrl_if #(.ADDR_WIDTH(AW), .M(M)) bus ();

  patch_fetch_ctrl #(.N(16), .M(M), .ADDR_WIDTH(AW), .STRIDE(STRIDE)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .p_mask    (p_mask),
    .err_count (err_count),
    .state_dbg (state_dbg),
    .cache     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  int lat[M];   // response latency L per lane (0 = first WAIT cycle)
  int kind[M];  // 0 hit, 1 error, 2 valid+error, 3 silent

  logic [AW-1:0] exp_q[$];      // expected request addresses of the current sequence
  logic [IW-1:0] exp_st_q[$];   // expected store_enable lanes, in order
  logic [IW-1:0] got_st_q[$];
  logic [AW-1:0] got_addr_q[$];
  logic [M-1:0]  exp_mask;
  int            exp_err;

  int req_count = 0, req_base = 0, st_base = 0, addr_base = 0;
  int seq_start = 0, exp_done_cyc = 0;
  bit seq_active = 1'b0;
  int resp_cyc = -1, resp_kind = 0;
  bit force_valid = 1'b0;
  int cmp_lane;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- cache responder ----------------
  always @(posedge clk) begin
    #1;
    bus.cache_valid = force_valid;
    bus.cache_error = 1'b0;
    if (cyc == resp_cyc) begin
      if (resp_kind == 0 || resp_kind == 2) bus.cache_valid = 1'b1;
      if (resp_kind == 1 || resp_kind == 2) bus.cache_error = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("read_write", 32'(bus.read_write), 32'd1);
    if (reset && seq_active) begin
      chk("busy", 32'(busy), 32'((cyc > seq_start) && (cyc < exp_done_cyc)));
      chk("done", 32'(done), 32'(cyc == exp_done_cyc));
    end
    if (bus.request) begin
      cmp_lane = req_count - req_base;
      got_addr_q.push_back(bus.address);
      if (seq_active) begin
        chk("req_in_range", 32'(cmp_lane < exp_q.size()), 32'd1);
        if (cmp_lane < exp_q.size())
          chk("req_addr", 32'(bus.address), 32'(exp_q[cmp_lane]));
        chk("req_index", 32'(bus.index), 32'(cmp_lane));
        resp_cyc  = cyc + 1 + lat[cmp_lane % M];
        resp_kind = kind[cmp_lane % M];
      end
      req_count++;
    end
    if (bus.store_enable) got_st_q.push_back(bus.index);
  end

  // ---------------- driver tasks ----------------
  task automatic setup_seq(input logic [AW-1:0] base);
    int total;
    total = 0;
    exp_q.delete();
    exp_st_q.delete();
    exp_mask = '0;
    exp_err  = 0;
    for (int i = 0; i < M; i++) begin
      exp_q.push_back(AW'(base + i * STRIDE));
      if (kind[i] == 0) begin
        exp_st_q.push_back(IW'(i));
        exp_mask[i] = 1'b1;
      end else begin
        exp_err++;
      end
      total += (kind[i] == 3) ? (2 + TIMEOUT_CYCLES) : (3 + lat[i]);
    end
    req_base     = req_count;
    st_base      = got_st_q.size();
    addr_base    = got_addr_q.size();
    seq_start    = cyc;
    exp_done_cyc = cyc + total + 1;
    seq_active   = 1'b1;
    base_addr    = base;
    start        = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = AW'($urandom);
    chk("mask_cleared", 32'(p_mask), 32'd0);
    chk("err_cleared", 32'(err_count), 32'd0);
  endtask

  task automatic finish_seq(input bit glitch);
    while (cyc <= exp_done_cyc) begin
      start = glitch && ((cyc == seq_start + 10) || (cyc == exp_done_cyc));
      tick();
    end
    start = 1'b0;
    chk("p_mask", 32'(p_mask), 32'(exp_mask));
    chk("err_count", 32'(err_count), 32'(exp_err));
    chk("req_total", 32'(req_count - req_base), 32'(M));
    chk("store_total", 32'(got_st_q.size() - st_base), 32'(exp_st_q.size()));
    for (int k = 0; k < exp_st_q.size() && (st_base + k) < got_st_q.size(); k++)
      chk("store_index", 32'(got_st_q[st_base + k]), 32'(exp_st_q[k]));
    chk("back_to_idle", 32'(state_dbg), 32'(IDLE));
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_request"}, 32'(bus.request), 32'd0);
    chk({pfx, "_store"}, 32'(bus.store_enable), 32'd0);
    chk({pfx, "_index"}, 32'(bus.index), 32'd0);
    chk({pfx, "_address"}, 32'(bus.address), 32'd0);
    chk({pfx, "_p_mask"}, 32'(p_mask), 32'd0);
    chk({pfx, "_err_count"}, 32'(err_count), 32'd0);
    chk({pfx, "_read_write"}, 32'(bus.read_write), 32'd1);
    chk({pfx, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  task automatic set_all(input int l, input int k);
    for (int i = 0; i < M; i++) begin
      lat[i]  = l;
      kind[i] = k;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.cache_valid = 1'b0;
    bus.cache_error = 1'b0;
    set_all(0, 0);
    repeat (3) tick();
    chk_reset_outputs("por");
    reset = 1'b1;
    tick();

    // All hits, L=2, from 0x100.
    set_all(2, 0);
    setup_seq(21'h100);
    chk("model_latency", 32'(exp_done_cyc - seq_start), 32'd81);
    finish_seq(1'b0);
    chk("t1_mask_lit", 32'(p_mask), 32'hFFFF);
    chk("t1_err_lit", 32'(err_count), 32'd0);
    chk("t1_first_addr", 32'(got_addr_q[addr_base]), 32'h100);
    chk("t1_last_addr", 32'(got_addr_q[addr_base + 15]), 32'h10F);

    // Back-to-back start; errors on lanes 3 and 12 (12 has valid+error); stray starts.
    for (int i = 0; i < M; i++) lat[i] = i % 4;
    kind[3]  = 1;
    kind[12] = 2;
    setup_seq(21'h0ABCDE);
    finish_seq(1'b1);
    chk("t2_mask_lit", 32'(p_mask), 32'hEFF7);
    chk("t2_err_lit", 32'(err_count), 32'd2);

    // Address wrap at 2^21 with zero-latency responses.
    set_all(0, 0);
    setup_seq(21'h1FFFFE);
    finish_seq(1'b0);
    chk("wrap_addr0", 32'(got_addr_q[addr_base]), 32'h1FFFFE);
    chk("wrap_addr2", 32'(got_addr_q[addr_base + 2]), 32'h0);
    chk("wrap_mask", 32'(p_mask), 32'hFFFF);

`ifdef PATCH_TIMEOUT_EN
    // Lane 7 never answers and must be abandoned after the timeout.
    set_all(1, 0);
    kind[7] = 3;
    setup_seq(21'h000200);
    finish_seq(1'b0);
    chk("tmo_mask_lit", 32'(p_mask), 32'hFF7F);
    chk("tmo_err_lit", 32'(err_count), 32'd1);
`endif

    // Reset while waiting on lane 5, then a late response must be ignored.
    set_all(0, 0);
    kind[5] = 3;
    setup_seq(21'h000040);
    for (int n = 0; n < 200 && (req_count - req_base) < 6; n++) tick();
    chk("rst_reached_lane5", 32'(req_count - req_base), 32'd6);
    tick();
    tick();
    chk("rst_in_wait", 32'(state_dbg), 32'(WAIT));
    seq_active = 1'b0;
    #1 reset = 1'b0;
    #1 chk("rst_async_state", 32'(state_dbg), 32'(IDLE));
    tick();
    chk_reset_outputs("midrst");
    reset = 1'b1;
    force_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("late_store", 32'(bus.store_enable), 32'd0);
    chk("late_state", 32'(state_dbg), 32'(IDLE));
    #1 force_valid = 1'b0;
    tick();
    tick();

    // Recovery after the aborted sequence.
    set_all(0, 0);
    kind[0]  = 1;
    kind[15] = 1;
    setup_seq(21'h001000);
    finish_seq(1'b0);
    chk("rec_mask_lit", 32'(p_mask), 32'h7FFE);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/patch_fetch_ctrl.md
Name: patch_fetch_ctrl

Overview:
- Sequencer for the patching datapath. On `start`, it issues M read requests to the patch cache at consecutive strided addresses.
- For each hit, it steers the returned activation into the cache-activation register file via `index`/`store_enable`.
- It builds the per-lane patching mask: 1 selects the cached value, 0 falls back to the original.
- Sits between the layer scheduler and the patching top; it drives that block's request/read_write/address/index/store_enable/p inputs.

Parameters:
- N, 16, activation width (bits); not used by the controller's datapath, kept for package consistency.
- M, 16, activations per patch (lanes); must be ≥2.
- ADDR_WIDTH, 21, cache address width.
- STRIDE, 1, address increment between consecutive lanes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a fetch sequence; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  address of lane 0, latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse when the sequence completes.
- request  out  1  cache request strobe.
- read_write  out  1  constant 1 (read).
- address  out  ADDR_WIDTH  cache address.
- cache_valid  in  1  cache valid response.
- cache_error  in  1  cache error response.
- index  out  $clog2(M)  destination lane for store.
- store_enable  out  1  capture activation_out into lane `index`.
- p_mask  out  M  patching bits; bit i=1 means lane i was fetched successfully.
- err_count  out  $clog2(M)+1  number of lanes that returned error in the last sequence.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; lane counter=0.
  - busy=0, done=0, request=0, store_enable=0, index=0, address=0, p_mask=0, err_count=0.
  - Reset mid-sequence aborts immediately; any outstanding cache response after reset release is ignored because the FSM is in IDLE.
- FSM states: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE:
  - start=1: latch base_addr; clear lane=0, p_mask=0, err_count=0; go to ISSUE.
  - start while not in IDLE is ignored.
- ISSUE (one cycle):
  - request=1, address=base+lane*STRIDE (registered), index=lane.
  - Go to WAIT.
- WAIT:
  - request=0; address and index are held.
  - cache_valid=1: store_enable=1 in the same cycle (combinational from state and cache_valid); p_mask[lane]<=1; go to NEXT.
  - cache_error=1 (valid=0): store_enable=0; p_mask[lane] stays 0; err_count<=err_count+1; go to NEXT.
  - valid and error both high: treat as error, no store.
  - Neither high: remain in WAIT indefinitely, unless PATCH_TIMEOUT_EN is defined.
- NEXT:
  - lane==M-1: go to DONE.
  - Otherwise: lane<=lane+1; go to ISSUE.
- DONE (one cycle):
  - done=1, busy=0; go to IDLE.
  - A start in the cycle after DONE (IDLE) is accepted.
- Hold rules: p_mask and err_count hold their values until the next accepted start.
- Latency:
  - Per lane = 3 cycles + cache response latency L; a full sequence is M*(3+L)+1 cycles from start to done.
  - Minimum throughput is one lane per 3 cycles with L=0; a response in the first WAIT cycle is legal.
- Address arithmetic: modulo 2^ADDR_WIDTH; wrap-around is silent.
- read_write is tied to 1 at all times, including during reset.

Optional Feature:
- Macro: PATCH_TIMEOUT_EN.
- Defined:
  - A counter of width 8 (localparam TIMEOUT_CYCLES=255) runs in WAIT and clears on entry.
  - If it reaches TIMEOUT_CYCLES with no response, the lane is treated as an error: p_mask bit 0, err_count+1, go to NEXT.
  - A response arriving in the same cycle as expiry takes priority over the timeout.
- Not defined: no counter; WAIT waits forever.

Decomposition:
- Package patch_pkg:
  - typedef enum logic [2:0] state_t {IDLE, ISSUE, WAIT, NEXT, DONE}.
  - localparam TIMEOUT_CYCLES.
  - Default N/M/ADDR_WIDTH constants.
- Single module; no sub-module needed. The address generator is an accumulator (addr<=addr+STRIDE in NEXT), not a multiplier.

Test Plan:
- Reset mid-WAIT (lane 5) -> next cycle all outputs at reset values; late cache_valid produces no store_enable.
- Cache model with L=2, all hits, base_addr=0x100, STRIDE=1:
  - addresses 0x100..0x10F issued in order.
  - index 0..15 with one store_enable each.
  - p_mask=16'hFFFF, err_count=0, done exactly 16*5+1 cycles after start.
- Errors on lanes 3 and 12 -> p_mask=16'hEFF7, err_count=2, no store_enable for lanes 3 and 12.
- base_addr=21'h1FFFFE, STRIDE=1 -> third address wraps to 0x000000; sequence completes normally.
- start pulsed during busy and in the DONE cycle -> ignored; start one cycle after done -> new sequence, p_mask cleared to 0 at that point.
- PATCH_TIMEOUT_EN defined, lane 7 never answered -> after 255 WAIT cycles lane 7 is marked error, p_mask[7]=0, err_count=1, lanes 8..15 proceed.
